ps2_keycode: RTL and testbench
==============================

# ps2_keycode

PS/2 keyboard receiver and scan-code decoder that drives the `keycode` input of `hack_soc`. It replaces the button-driven test keyboard counter. The block samples the asynchronous PS/2 clock and data lines and deframes 11-bit device-to-host frames. It tracks make, break and extended prefixes and holds the Hack keyboard code of the currently pressed key, or 0 when no key is pressed.

## Interface
Parameters:
- `FILTER_CYCLES`, 8: consecutive `clk` cycles the synchronized `ps2_clk` must hold a new level before that level is accepted.
- `TIMEOUT_CYCLES`, 25000: `clk` cycles without an accepted falling edge inside a frame before the frame is aborted (1 ms at 25.125 MHz).

Ports (reset is synchronous, active-high; the clock is `clk`):
- `clk`  in  1  system clock, the 25.125 MHz video clock.
- `reset`  in  1  synchronous, active-high.
- `ps2_clk`  in  1  PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  PS/2 data pin, asynchronous.
- `keycode`  out  8  Hack code of the held key; 0 when no key is held.
- `key_valid`  out  1  one-cycle pulse when `keycode` is loaded by a make code.
- `frame_error`  out  1  one-cycle pulse on a start, parity, stop or timeout error.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - Filter: a counter runs while the synchronized clock differs from the filtered clock. It clears on a match. When it reaches `FILTER_CYCLES`, the filtered clock takes the new level.
  - A falling edge of the filtered clock samples the synchronized data. This falling edge is called a "bit edge" below.
- **Frame FSM states**: IDLE, DATA, PARITY, STOP.
  - IDLE: a bit edge with data 0 (start bit) → DATA with bit count 0. A bit edge with data 1 is ignored.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: latch the parity bit → STOP.
  - STOP: the frame is good if the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). A good frame raises the internal `byte_ready` strobe. A bad frame pulses `frame_error`. Either way → IDLE.
  - Timeout: in any state other than IDLE, a counter of cycles since the last bit edge that reaches `TIMEOUT_CYCLES` forces IDLE and pulses `frame_error`. The partial byte is discarded.
  - Any `frame_error` also clears the `ext` and `brk` flags.
- **Decoder**, acting on `byte_ready`:
  - Byte E0 sets `ext`. Byte F0 sets `brk`. These are prefixes and have no other effect.
  - Any other byte is looked up as {`ext`, byte} → Hack code. Both flags then clear.
  - Code 0 (unmapped): no output change.
  - `brk`=1: if the code equals `keycode`, `keycode` ← 0. A break for a different key is ignored.
  - `brk`=0: `keycode` ← code and `key_valid` pulses. Typematic repeats re-pulse `key_valid` with the same code.
- **Mapping table** (scan code → Hack code, no prefix unless noted):
  - Letters → 65–90 (upper case): A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
  - Digits 0–9 → 48–57: 45, 16, 1E, 26, 25, 2E, 36, 3D, 3E, 46.
  - Named keys: space 29→32, enter 5A→128, backspace 66→129, escape 76→140.
  - Extended keys (E0 prefix): left 6B→130, up 75→131, right 74→132, down 72→133, home 6C→134, end 69→135, page-up 7D→136, page-down 7A→137, insert 70→138, delete 71→139.
  - Every other {`ext`, byte} → 0.

## Timing
- **Reset values**: `keycode`=0, `key_valid`=0, `frame_error`=0. The FSM is in IDLE. `ext`, `brk`, the shift register, the filter counter and the timeout counter are all 0. The filtered clock is 1.
- **Reset mid-frame** abandons the frame with no `frame_error`. The next accepted frame must start with a new start bit.
- **Edge latency**: the bit edge is accepted 2 (synchronizer) + `FILTER_CYCLES` cycles after the pin falls. Data is sampled from the synchronizer in that same cycle.
- **Output latency**: `byte_ready` is asserted 1 cycle after the stop-bit edge. `keycode` and `key_valid` (or `frame_error` for a bad frame) update 1 cycle after that.
- **Simultaneous timeout and bit edge**: the bit edge wins and the timeout counter clears.
- Pulses shorter than `FILTER_CYCLES` on `ps2_clk` are ignored.

## Test plan
Bench setup: `FILTER_CYCLES`=8, `TIMEOUT_CYCLES`=500, PS/2 half-period 40 `clk` cycles, data changes mid-high.
- Send frame 1C (parity 0, stop 1) → `keycode`=65 with one `key_valid` pulse, no `frame_error`. Then send F0, 1C → `keycode`=0 and no further `key_valid`.
- Send E0, 75 → `keycode`=131. Send E0, F0, 75 → `keycode`=0. Send 75 alone → `keycode`=0 (unmapped).
- Press 1C then 32 (`keycode`=66), then send F0, 1C → `keycode` stays 66. Then send F0, 32 → 0.
- Send 1C with parity bit 1 → `frame_error` pulses, `keycode` unchanged. Send 1C with stop bit 0 → same result.
- Clock 4 bits then stop → `frame_error` 500 cycles after the last edge. A following valid 29 → `keycode`=32.
- Apply 5-cycle low glitches on `ps2_clk` while idle → no state change. Assert `reset` mid-frame → all outputs 0, no `frame_error`. A following valid 5A → `keycode`=128.

Source files
------------

// File: rtl/ps2_keycode.sv
// rtl/ps2_keycode.sv - PS/2 keyboard receiver and scan-code to Hack keycode decoder
module ps2_keycode #(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       frame_error
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_ready_q, byte_ready_d;
    logic          err_q, err_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [7:0]    keycode_q, keycode_d;
    logic          key_valid_q, key_valid_d;
    logic          frame_error_q, frame_error_d;
    logic          bit_edge;
    logic          bit_data;
    logic [7:0]    code;

    assign keycode     = keycode_q;
    assign key_valid   = key_valid_q;
    assign frame_error = frame_error_q;
    assign bit_data    = data_sync_q[1];

    // Two-stage synchronizers and the glitch filter on the PS/2 clock
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_clk_d  = filt_clk_q;
        filt_cnt_d  = '0;
        if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) begin
                filt_clk_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        bit_edge = filt_clk_q & ~filt_clk_d;
    end

    // Frame deserializer with parity/stop checking and inter-bit timeout
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        byte_ready_d = 1'b0;
        err_d        = 1'b0;
        to_cnt_d     = (state_q == S_IDLE) ? '0 : to_cnt_q + 1'b1;
        if (bit_edge) begin
            to_cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!bit_data) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                        shift_d   = 8'h00;
                    end
                end
                S_DATA: begin
                    shift_d   = {bit_data, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = bit_data;
                    state_d = S_STOP;
                end
                default: begin
                    if (bit_data && ((^shift_q) ^ par_q)) byte_ready_d = 1'b1;
                    else                                  err_d        = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d  = S_IDLE;
            to_cnt_d = '0;
            err_d    = 1'b1;
        end
    end

    // Scan-code lookup; the ext flag selects the E0-prefixed page
    always_comb begin
        case ({ext_q, shift_q})
            9'h01C: code = 8'd65;  9'h032: code = 8'd66;  9'h021: code = 8'd67;
            9'h023: code = 8'd68;  9'h024: code = 8'd69;  9'h02B: code = 8'd70;
            9'h034: code = 8'd71;  9'h033: code = 8'd72;  9'h043: code = 8'd73;
            9'h03B: code = 8'd74;  9'h042: code = 8'd75;  9'h04B: code = 8'd76;
            9'h03A: code = 8'd77;  9'h031: code = 8'd78;  9'h044: code = 8'd79;
            9'h04D: code = 8'd80;  9'h015: code = 8'd81;  9'h02D: code = 8'd82;
            9'h01B: code = 8'd83;  9'h02C: code = 8'd84;  9'h03C: code = 8'd85;
            9'h02A: code = 8'd86;  9'h01D: code = 8'd87;  9'h022: code = 8'd88;
            9'h035: code = 8'd89;  9'h01A: code = 8'd90;
            9'h045: code = 8'd48;  9'h016: code = 8'd49;  9'h01E: code = 8'd50;
            9'h026: code = 8'd51;  9'h025: code = 8'd52;  9'h02E: code = 8'd53;
            9'h036: code = 8'd54;  9'h03D: code = 8'd55;  9'h03E: code = 8'd56;
            9'h046: code = 8'd57;
            9'h029: code = 8'd32;  9'h05A: code = 8'd128; 9'h066: code = 8'd129;
            9'h076: code = 8'd140;
            9'h16B: code = 8'd130; 9'h175: code = 8'd131; 9'h174: code = 8'd132;
            9'h172: code = 8'd133; 9'h16C: code = 8'd134; 9'h169: code = 8'd135;
            9'h17D: code = 8'd136; 9'h17A: code = 8'd137; 9'h170: code = 8'd138;
            9'h171: code = 8'd139;
            default: code = 8'd0;
        endcase
    end

    // Prefix tracking and held-key register, one cycle after a byte completes
    always_comb begin
        ext_d         = ext_q;
        brk_d         = brk_q;
        keycode_d     = keycode_q;
        key_valid_d   = 1'b0;
        frame_error_d = err_q;
        if (err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ready_q) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (code != 8'd0) begin
                    if (brk_q) begin
                        if (code == keycode_q) keycode_d = 8'd0;
                    end else begin
                        keycode_d   = code;
                        key_valid_d = 1'b1;
                    end
                end
            end
        end
    end

    // State registers; the lines idle high so synchronizers reset to 1
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q    <= 2'b11;
            data_sync_q   <= 2'b11;
            filt_clk_q    <= 1'b1;
            filt_cnt_q    <= '0;
            state_q       <= S_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            par_q         <= 1'b0;
            to_cnt_q      <= '0;
            byte_ready_q  <= 1'b0;
            err_q         <= 1'b0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            keycode_q     <= 8'd0;
            key_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            clk_sync_q    <= clk_sync_d;
            data_sync_q   <= data_sync_d;
            filt_clk_q    <= filt_clk_d;
            filt_cnt_q    <= filt_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            to_cnt_q      <= to_cnt_d;
            byte_ready_q  <= byte_ready_d;
            err_q         <= err_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            keycode_q     <= keycode_d;
            key_valid_q   <= key_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

endmodule

// File: tb/tb_ps2_keycode.sv
// tb/tb_ps2_keycode.sv - self-checking bench for ps2_keycode
module tb_ps2_keycode;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_valid;
    logic       frame_error;

    ps2_keycode #(.FILTER_CYCLES(8), .TIMEOUT_CYCLES(500)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .key_valid(key_valid), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_fall = 0;
    int kv_seen = 0;
    int fe_seen = 0;

    // reference model state
    int         key_map[int];
    logic [7:0] exp_kc = 8'd0;
    int         exp_kv = 0;
    int         exp_fe = 0;
    bit         m_ext = 0;
    bit         m_brk = 0;
    int         pool[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_valid === 1'b1) kv_seen++;
        if (frame_error === 1'b1) fe_seen++;
    end

    task automatic build_map();
        int letters[26] = '{'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B, 'h34, 'h33, 'h43, 'h3B,
                            'h42, 'h4B, 'h3A, 'h31, 'h44, 'h4D, 'h15, 'h2D, 'h1B, 'h2C,
                            'h3C, 'h2A, 'h1D, 'h22, 'h35, 'h1A};
        int digits[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
        int extk[10] = '{'h6B, 'h75, 'h74, 'h72, 'h6C, 'h69, 'h7D, 'h7A, 'h70, 'h71};
        for (int i = 0; i < 26; i++) begin key_map[letters[i]] = 65 + i; pool.push_back(letters[i]); end
        for (int i = 0; i < 10; i++) begin key_map[digits[i]] = 48 + i; pool.push_back(digits[i]); end
        for (int i = 0; i < 10; i++) begin key_map[256 + extk[i]] = 130 + i; pool.push_back(extk[i]); end
        key_map['h29] = 32;  key_map['h5A] = 128; key_map['h66] = 129; key_map['h76] = 140;
        pool.push_back('h29); pool.push_back('h5A); pool.push_back('h66); pool.push_back('h76);
    endtask

    task automatic model_byte(input int b);
        int code;
        if (b == 'hE0) m_ext = 1;
        else if (b == 'hF0) m_brk = 1;
        else begin
            code = key_map.exists(m_ext * 256 + b) ? key_map[m_ext * 256 + b] : 0;
            if (code != 0) begin
                if (m_brk) begin
                    if (code == int'(exp_kc)) exp_kc = 8'd0;
                end else begin
                    exp_kc = code[7:0];
                    exp_kv++;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            wait_cyc(20);
            ps2_data = bits[i];
            wait_cyc(20);
            ps2_clk = 1'b0;
            last_fall = cyc;
            wait_cyc(40);
            ps2_clk = 1'b1;
        end
        wait_cyc(20);
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input int b, input bit par_flip, input bit stop_bit);
        logic [7:0] d;
        logic       par;
        d   = b[7:0];
        par = ~(^d) ^ par_flip;
        send_bits({stop_bit, par, d, 1'b0}, 11);
        if (par_flip || !stop_bit) begin
            m_ext = 0;
            m_brk = 0;
            exp_fe++;
        end else begin
            model_byte(b);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        exp_kc = 8'd0;
        m_ext = 0;
        m_brk = 0;
        wait_cyc(2);
    endtask

    task automatic test_reset();
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        do_reset();
        total++; if (keycode !== 8'd0) begin bad++; $display("FAIL reset_keycode: got %0d want 0", keycode); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
    endtask

    task automatic test_make_break();
        send_byte('h1C, 0, 1);
        total++; if (keycode !== 8'd65) begin bad++; $display("FAIL make_a_kc: got %0d want 65", keycode); end
        total++; if (kv_seen !== 1) begin bad++; $display("FAIL make_a_kv: got %0d want 1", kv_seen); end
        total++; if (fe_seen !== 0) begin bad++; $display("FAIL make_a_fe: got %0d want 0", fe_seen); end
        send_byte('hF0, 0, 1);
        send_byte('h1C, 0, 1);
        total++; if (keycode !== 8'd0) begin bad++; $display("FAIL break_a_kc: got %0d want 0", keycode); end
        total++; if (kv_seen !== 1) begin bad++; $display("FAIL break_a_kv: got %0d want 1", kv_seen); end
    endtask

    task automatic test_extended();
        send_byte('hE0, 0, 1);
        send_byte('h75, 0, 1);
        total++; if (keycode !== 8'd131) begin bad++; $display("FAIL ext_up_kc: got %0d want 131", keycode); end
        send_byte('hE0, 0, 1);
        send_byte('hF0, 0, 1);
        send_byte('h75, 0, 1);
        total++; if (keycode !== 8'd0) begin bad++; $display("FAIL ext_up_break: got %0d want 0", keycode); end
        send_byte('h75, 0, 1);
        total++; if (keycode !== 8'd0) begin bad++; $display("FAIL unmapped_75: got %0d want 0", keycode); end
        total++; if (kv_seen !== exp_kv) begin bad++; $display("FAIL ext_kv_count: got %0d want %0d", kv_seen, exp_kv); end
    endtask

    task automatic test_two_keys();
        send_byte('h1C, 0, 1);
        send_byte('h32, 0, 1);
        total++; if (keycode !== 8'd66) begin bad++; $display("FAIL two_b_kc: got %0d want 66", keycode); end
        send_byte('hF0, 0, 1);
        send_byte('h1C, 0, 1);
        total++; if (keycode !== 8'd66) begin bad++; $display("FAIL stale_break_kc: got %0d want 66", keycode); end
        send_byte('hF0, 0, 1);
        send_byte('h32, 0, 1);
        total++; if (keycode !== 8'd0) begin bad++; $display("FAIL break_b_kc: got %0d want 0", keycode); end
    endtask

    task automatic test_bad_frames();
        int fe0;
        logic [7:0] kc0;
        fe0 = fe_seen;
        kc0 = keycode;
        send_byte('h1C, 1, 1);
        total++; if (fe_seen !== fe0 + 1) begin bad++; $display("FAIL parity_fe: got %0d want %0d", fe_seen, fe0 + 1); end
        total++; if (keycode !== kc0) begin bad++; $display("FAIL parity_kc: got %0d want %0d", keycode, kc0); end
        send_byte('h1C, 0, 0);
        total++; if (fe_seen !== fe0 + 2) begin bad++; $display("FAIL stop_fe: got %0d want %0d", fe_seen, fe0 + 2); end
        total++; if (keycode !== kc0) begin bad++; $display("FAIL stop_kc: got %0d want %0d", keycode, kc0); end
        total++; if (kv_seen !== exp_kv) begin bad++; $display("FAIL bad_kv_count: got %0d want %0d", kv_seen, exp_kv); end
    endtask

    task automatic test_timeout();
        int fe0;
        int k;
        int delta;
        fe0 = fe_seen;
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4);
        k = 0;
        while (fe_seen == fe0 && k < 1000) begin
            wait_cyc(1);
            k++;
        end
        delta = cyc - last_fall;
        m_ext = 0;
        m_brk = 0;
        exp_fe++;
        total++;
        if (fe_seen != fe0 + 1 || delta < 500 || delta > 540) begin
            bad++;
            $display("FAIL timeout_fe: errors=%0d delay=%0d want errors=%0d delay 500..540", fe_seen - fe0, delta, 1);
        end
        send_byte('h29, 0, 1);
        total++; if (keycode !== 8'd32) begin bad++; $display("FAIL after_timeout_kc: got %0d want 32", keycode); end
    endtask

    task automatic test_glitch();
        int fe0;
        int kv0;
        logic [7:0] kc0;
        fe0 = fe_seen;
        kv0 = kv_seen;
        kc0 = keycode;
        ps2_data = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ps2_clk = 1'b0;
            wait_cyc(5);
            ps2_clk = 1'b1;
            wait_cyc(30);
        end
        ps2_data = 1'b1;
        wait_cyc(600);
        total++; if (fe_seen !== fe0) begin bad++; $display("FAIL glitch_fe: got %0d want %0d", fe_seen, fe0); end
        total++; if (kv_seen !== kv0 || keycode !== kc0) begin bad++; $display("FAIL glitch_state: kc %0d kv %0d want kc %0d kv %0d", keycode, kv_seen, kc0, kv0); end
        send_byte('h1C, 0, 1);
        total++; if (keycode !== 8'd65) begin bad++; $display("FAIL post_glitch_kc: got %0d want 65", keycode); end
    endtask

    task automatic test_reset_midframe();
        int fe0;
        fe0 = fe_seen;
        send_bits({1'b1, 1'b0, 8'h32, 1'b0}, 5);
        do_reset();
        total++; if (keycode !== 8'd0 || key_valid !== 1'b0 || frame_error !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: kc %0d kv %b fe %b want 0 0 0", keycode, key_valid, frame_error);
        end
        wait_cyc(700);
        total++; if (fe_seen !== fe0) begin bad++; $display("FAIL midreset_fe: got %0d want %0d", fe_seen, fe0); end
        send_byte('h5A, 0, 1);
        total++; if (keycode !== 8'd128) begin bad++; $display("FAIL post_reset_kc: got %0d want 128", keycode); end
    endtask

    task automatic test_random();
        int r;
        int b;
        bit flip;
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) b = 'hE0;
            else if (r < 4) b = 'hF0;
            else if (r == 4) b = $urandom_range(0, 255);
            else b = pool[$urandom_range(0, pool.size() - 1)];
            flip = ($urandom_range(0, 9) == 0);
            send_byte(b, flip, 1);
            total++;
            if (keycode !== exp_kc || kv_seen !== exp_kv || fe_seen !== exp_fe) begin
                bad++;
                $display("FAIL random_%0d byte %h: kc %0d kv %0d fe %0d want kc %0d kv %0d fe %0d",
                         n, b, keycode, kv_seen, fe_seen, exp_kc, exp_kv, exp_fe);
            end
        end
    endtask

    initial begin
        build_map();
        test_reset();
        test_make_break();
        test_extended();
        test_two_keys();
        test_bad_frames();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
